// File: rtl/aligner_fifo_ctrl.sv
// aligner_fifo_ctrl
// Sequencing controller for one aligner_fifo instance. It latches the run
// configuration, holds the aligner in reset while configuring or recovering,
// and gates both input valids. It watches the second stream arrive within
// cfg_delay + TIMEOUT_MARGIN of the first, and watches the aligner statuses.
// It makes a bounded number of automatic recoveries before going to ERROR,
// and drains cleanly on stop.
//
// Ports
//   clk            clock
//   aresetn        synchronous reset, active HIGH despite the name
//   start_i        pulse: latch cfg_delay_i and arm (IDLE only)
//   stop_i         pulse: drain and return to IDLE
//   clear_i        pulse: leave ERROR, zero the counters
//   cfg_delay_i    expected 1st->2nd stream delay, cycles
//   vld_1st_i      raw first-stream valid
//   vld_2d_i       raw second-stream valid
//   vld_o_mon_i    aligner vld_o, monitored
//   statuses_i     aligner statuses {2d missing, 1st missing, underflow, overflow}
//   delay_o        latched delay for the aligner
//   aligner_rst_o  active-high reset to the aligner
//   vld_1st_o      gated first-stream valid
//   vld_2d_o       gated second-stream valid
//   state_o        encoded state
//   busy_o         state is neither IDLE nor ERROR
//   err_o          high in ERROR
//   retry_cnt_o    recoveries since the last start, saturating
//   aligned_cnt_o  vld_o pulses seen in RUN, saturating
module aligner_fifo_ctrl #(
  parameter int WIDTH_FIFO     = 32,
  parameter int DLY_W          = 16,
  parameter int RST_CYCLES     = 8,
  parameter int TIMEOUT_MARGIN = 64,
  parameter int MAX_RETRY      = 3,
  parameter int DRAIN_IDLE     = 16
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             clear_i,
  input  logic [DLY_W-1:0] cfg_delay_i,
  input  logic             vld_1st_i,
  input  logic             vld_2d_i,
  input  logic             vld_o_mon_i,
  input  logic [3:0]       statuses_i,
  output logic [DLY_W-1:0] delay_o,
  output logic             aligner_rst_o,
  output logic             vld_1st_o,
  output logic             vld_2d_o,
  output logic [2:0]       state_o,
  output logic             busy_o,
  output logic             err_o,
  output logic [1:0]       retry_cnt_o,
  output logic [31:0]      aligned_cnt_o
);

  localparam int WAIT_W = DLY_W + 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CFG     = 3'd1;
  localparam logic [2:0] S_ARM     = 3'd2;
  localparam logic [2:0] S_FILL    = 3'd3;
  localparam logic [2:0] S_RUN     = 3'd4;
  localparam logic [2:0] S_RECOVER = 3'd5;
  localparam logic [2:0] S_DRAIN   = 3'd6;
  localparam logic [2:0] S_ERROR   = 3'd7;

  if (WIDTH_FIFO < 1 || RST_CYCLES < 1 || DRAIN_IDLE < 1) begin : g_param_check
    $error("aligner_fifo_ctrl: WIDTH_FIFO, RST_CYCLES and DRAIN_IDLE must be >= 1");
  end

  logic [2:0]        r_state;
  logic [DLY_W-1:0]  r_delay;
  logic [WAIT_W-1:0] r_wait;
  logic [31:0]       r_hold;
  logic [31:0]       r_idle;
  logic              r_stop_pend;
  logic [1:0]        r_retry;
  logic [31:0]       r_aligned;

  logic [WAIT_W-1:0] w_limit;
  logic [WAIT_W-1:0] w_wait_nxt;
  logic              w_timeout;
  logic              w_hold_done;
  logic              w_stop_req;
  logic [1:0]        w_retry_inc;
  logic              w_en_1st;
  logic              w_en_2d;

  // The limit is one bit wider than the delay, so a large cfg_delay plus the
  // margin cannot wrap into an early timeout.
  assign w_limit     = {1'b0, r_delay} + WAIT_W'(TIMEOUT_MARGIN);
  // r_wait holds the count of the previous FILL cycle. The ARM cycle that saw
  // the first valid counts as 0, so the first FILL cycle counts as 1.
  assign w_wait_nxt  = r_wait + 1'b1;
  assign w_timeout   = (w_wait_nxt >= w_limit);
  assign w_hold_done = (r_hold == 32'(RST_CYCLES - 1));
  // A stop that arrives during a reset hold is remembered until the hold ends.
  assign w_stop_req  = r_stop_pend | stop_i;
  assign w_retry_inc = (r_retry == 2'd3) ? r_retry : r_retry + 2'd1;

  always_ff @(posedge clk) begin
    if (aresetn) begin
      r_state     <= S_IDLE;
      r_delay     <= '0;
      r_wait      <= '0;
      r_hold      <= '0;
      r_idle      <= '0;
      r_stop_pend <= 1'b0;
      r_retry     <= '0;
      r_aligned   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_state     <= S_CFG;
            r_delay     <= cfg_delay_i;
            r_retry     <= '0;
            r_aligned   <= '0;
            r_hold      <= '0;
            r_stop_pend <= 1'b0;
          end
        end
        S_CFG, S_RECOVER: begin
          r_stop_pend <= w_stop_req;
          if (w_hold_done) begin
            r_hold <= '0;
            if (w_stop_req)
              r_state <= S_IDLE;
            else if (r_state == S_CFG || 32'(r_retry) < MAX_RETRY)
              r_state <= S_ARM;
            else
              r_state <= S_ERROR;
          end else begin
            r_hold <= r_hold + 32'd1;
          end
        end
        S_ARM: begin
          if (stop_i) begin
            r_state <= S_DRAIN;
            r_idle  <= '0;
          end else if (vld_1st_i) begin
            r_state <= S_FILL;
            r_wait  <= '0;
          end
        end
        S_FILL: begin
          // A second-stream valid on the timeout cycle still counts as arrival.
          if (stop_i) begin
            r_state <= S_DRAIN;
            r_idle  <= '0;
          end else if (vld_2d_i) begin
            r_state <= S_RUN;
          end else if (w_timeout) begin
            r_state     <= S_RECOVER;
            r_retry     <= w_retry_inc;
            r_hold      <= '0;
            r_stop_pend <= 1'b0;
          end else begin
            r_wait <= w_wait_nxt;
          end
        end
        S_RUN: begin
          if (vld_o_mon_i && (r_aligned != '1))
            r_aligned <= r_aligned + 32'd1;
          if (stop_i) begin
            r_state <= S_DRAIN;
            r_idle  <= '0;
          end else if (|statuses_i) begin
            r_state     <= S_RECOVER;
            r_retry     <= w_retry_inc;
            r_hold      <= '0;
            r_stop_pend <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (vld_o_mon_i)
            r_idle <= '0;
          else if (r_idle == 32'(DRAIN_IDLE - 1))
            r_state <= S_IDLE;
          else
            r_idle <= r_idle + 32'd1;
        end
        S_ERROR: begin
          if (clear_i) begin
            r_state   <= S_IDLE;
            r_retry   <= '0;
            r_aligned <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_en_1st = (r_state == S_ARM) || (r_state == S_FILL) || (r_state == S_RUN);
  assign w_en_2d  = (r_state == S_FILL) || (r_state == S_RUN);

  assign delay_o       = r_delay;
  assign aligner_rst_o = (r_state == S_IDLE) || (r_state == S_CFG) ||
                         (r_state == S_RECOVER) || (r_state == S_ERROR);
  assign vld_1st_o     = vld_1st_i & w_en_1st;
  assign vld_2d_o      = vld_2d_i & w_en_2d;
  assign state_o       = r_state;
  assign busy_o        = (r_state != S_IDLE) && (r_state != S_ERROR);
  assign err_o         = (r_state == S_ERROR);
  assign retry_cnt_o   = r_retry;
  assign aligned_cnt_o = r_aligned;

endmodule

// File: tb/tb_aligner_fifo_ctrl.sv
module tb_aligner_fifo_ctrl;

  localparam int DLY_W = 16;
  localparam int RSTC  = 8;
  localparam int MARG  = 64;
  localparam int MAXR  = 3;
  localparam int DIDLE = 16;

  logic             clk;
  logic             t_rst, t_start, t_stop, t_clear;
  logic [DLY_W-1:0] t_cfg;
  logic             t_v1, t_v2, t_vmon;
  logic [3:0]       t_sts;
  logic [DLY_W-1:0] delay_o;
  logic             aligner_rst_o, vld_1st_o, vld_2d_o, busy_o, err_o;
  logic [2:0]       state_o;
  logic [1:0]       retry_cnt_o;
  logic [31:0]      aligned_cnt_o;

  aligner_fifo_ctrl #(
    .WIDTH_FIFO(32), .DLY_W(DLY_W), .RST_CYCLES(RSTC),
    .TIMEOUT_MARGIN(MARG), .MAX_RETRY(MAXR), .DRAIN_IDLE(DIDLE)
  ) dut (
    .clk(clk), .aresetn(t_rst), .start_i(t_start), .stop_i(t_stop),
    .clear_i(t_clear), .cfg_delay_i(t_cfg), .vld_1st_i(t_v1), .vld_2d_i(t_v2),
    .vld_o_mon_i(t_vmon), .statuses_i(t_sts), .delay_o(delay_o),
    .aligner_rst_o(aligner_rst_o), .vld_1st_o(vld_1st_o), .vld_2d_o(vld_2d_o),
    .state_o(state_o), .busy_o(busy_o), .err_o(err_o),
    .retry_cnt_o(retry_cnt_o), .aligned_cnt_o(aligned_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: phase plus countdowns/counters, stepped once per cycle.
  int     m_st = 0, m_delay = 0, m_retry = 0, m_left = 0, m_fill = 0, m_idle = 0;
  bit     m_pend = 0;
  longint m_aligned = 0;

  task automatic m_recover();
    m_st    = 5;
    m_retry = (m_retry < 3) ? m_retry + 1 : 3;
    m_left  = RSTC;
    m_pend  = 0;
  endtask

  task automatic m_drain();
    m_st   = 6;
    m_idle = 0;
  endtask

  task automatic model_next();
    if (t_rst) begin
      m_st = 0; m_delay = 0; m_retry = 0; m_aligned = 0; m_pend = 0;
      return;
    end
    case (m_st)
      0: if (t_start) begin
        m_st = 1; m_delay = int'(t_cfg); m_retry = 0; m_aligned = 0;
        m_left = RSTC; m_pend = 0;
      end
      1, 5: begin
        if (t_stop) m_pend = 1;
        m_left--;
        if (m_left == 0) begin
          if (m_pend) m_st = 0;
          else if (m_st == 1 || m_retry < MAXR) m_st = 2;
          else m_st = 7;
        end
      end
      2: if (t_stop) m_drain(); else if (t_v1) begin m_st = 3; m_fill = 0; end
      3: if (t_stop) m_drain();
         else begin
           m_fill++;
           if (t_v2) m_st = 4;
           else if (m_fill >= m_delay + MARG) m_recover();
         end
      4: begin
        if (t_vmon && m_aligned < 64'hFFFF_FFFF) m_aligned++;
        if (t_stop) m_drain();
        else if (t_sts != 4'd0) m_recover();
      end
      6: begin
        if (t_vmon) m_idle = 0; else m_idle++;
        if (m_idle == DIDLE) m_st = 0;
      end
      7: if (t_clear) begin m_st = 0; m_retry = 0; m_aligned = 0; end
      default: m_st = 0;
    endcase
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_cmp();
    bit e_arst, e_v1o, e_v2o, e_busy, e_err;
    e_arst = (m_st == 0 || m_st == 1 || m_st == 5 || m_st == 7);
    e_v1o  = t_v1 && (m_st == 2 || m_st == 3 || m_st == 4);
    e_v2o  = t_v2 && (m_st == 3 || m_st == 4);
    e_busy = (m_st != 0 && m_st != 7);
    e_err  = (m_st == 7);
    n_vec++;
    if (state_o !== 3'(m_st) || delay_o !== DLY_W'(m_delay) || aligner_rst_o !== e_arst ||
        vld_1st_o !== e_v1o || vld_2d_o !== e_v2o || busy_o !== e_busy || err_o !== e_err ||
        retry_cnt_o !== 2'(m_retry) || aligned_cnt_o !== 32'(m_aligned)) begin
      n_err++;
      $display("FAIL model t=%0t got st=%0d dly=%0d arst=%b v1o=%b v2o=%b busy=%b err=%b rty=%0d al=%0d expected st=%0d dly=%0d arst=%b v1o=%b v2o=%b busy=%b err=%b rty=%0d al=%0d",
               $time, state_o, delay_o, aligner_rst_o, vld_1st_o, vld_2d_o, busy_o, err_o,
               retry_cnt_o, aligned_cnt_o, m_st, m_delay, e_arst, e_v1o, e_v2o, e_busy,
               e_err, m_retry, m_aligned);
    end
  endtask

  // One clock: the model consumes the held inputs, the DUT clocks, then compare.
  task automatic step();
    model_next();
    @(posedge clk);
    #1;
    model_cmp();
  endtask

  task automatic clr_in();
    t_rst = 0; t_start = 0; t_stop = 0; t_clear = 0; t_cfg = '0;
    t_v1 = 0; t_v2 = 0; t_vmon = 0; t_sts = '0;
  endtask

  task automatic to_arm(input int d);
    clr_in();
    t_rst = 1; step(); t_rst = 0;
    t_start = 1; t_cfg = DLY_W'(d); step(); t_start = 0;
    repeat (RSTC) step();
    chk("arm_reached", state_o, 2);
  endtask

  typedef struct {
    int reps;
    bit rst, start, stop, clear;
    int cfg;
    bit v1, v2, vmon;
    int sts;
    int e_st, e_arst, e_v1o, e_v2o, e_busy, e_retry, e_al, e_dly;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int reps, bit rst, bit start, bit stop, bit clear, int cfg,
                              bit v1, bit v2, bit vmon, int sts, int e_st, int e_arst,
                              int e_v1o, int e_v2o, int e_busy, int e_retry, int e_al,
                              int e_dly);
    vec_t v;
    v.reps = reps; v.rst = rst; v.start = start; v.stop = stop; v.clear = clear;
    v.cfg = cfg; v.v1 = v1; v.v2 = v2; v.vmon = vmon; v.sts = sts;
    v.e_st = e_st; v.e_arst = e_arst; v.e_v1o = e_v1o; v.e_v2o = e_v2o;
    v.e_busy = e_busy; v.e_retry = e_retry; v.e_al = e_al; v.e_dly = e_dly;
    return v;
  endfunction

  initial begin
    clr_in();
    //                reps rst st sp cl cfg v1 v2 vm sts  st ar v1o v2o bsy rty al dly
    tbl.push_back(mk( 1, 1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk( 1, 0, 1, 0, 0, 3, 0, 0, 0, 0,   1, 1, 0, 0, 1, 0, 0, 3));
    tbl.push_back(mk( 6, 0, 0, 0, 0, 9, 0, 0, 0, 0,   1, 1, 0, 0, 1, 0, 0, 3));
    tbl.push_back(mk( 1, 0, 0, 0, 0, 0, 1, 0, 0, 0,   1, 1, 0, 0, 1, 0, 0, 3));
    tbl.push_back(mk( 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,   2, 0, 0, 0, 1, 0, 0, 3));
    tbl.push_back(mk( 1, 0, 0, 0, 0, 0, 1, 0, 0, 0,   3, 0, 1, 0, 1, 0, 0, 3));
    tbl.push_back(mk( 1, 0, 0, 0, 0, 0, 1, 1, 0, 0,   4, 0, 1, 1, 1, 0, 0, 3));
    tbl.push_back(mk( 5, 0, 0, 0, 0, 0, 0, 0, 1, 0,   4, 0, 0, 0, 1, 0, 5, 3));
    tbl.push_back(mk( 1, 0, 0, 0, 0, 0, 1, 0, 0, 2,   5, 1, 0, 0, 1, 1, 5, 3));
    tbl.push_back(mk( 7, 0, 0, 0, 0, 0, 1, 1, 0, 0,   5, 1, 0, 0, 1, 1, 5, 3));
    tbl.push_back(mk( 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,   2, 0, 0, 0, 1, 1, 5, 3));
    tbl.push_back(mk( 1, 0, 0, 1, 0, 0, 1, 1, 0, 0,   6, 0, 0, 0, 1, 1, 5, 3));
    tbl.push_back(mk( 1, 0, 0, 0, 0, 0, 0, 0, 1, 0,   6, 0, 0, 0, 1, 1, 5, 3));
    tbl.push_back(mk(15, 0, 0, 0, 0, 0, 0, 0, 0, 0,   6, 0, 0, 0, 1, 1, 5, 3));
    tbl.push_back(mk( 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 1, 5, 3));
    tbl.push_back(mk( 1, 0, 1, 1, 0, 5, 0, 0, 0, 0,   1, 1, 0, 0, 1, 0, 0, 5));
    tbl.push_back(mk( 1, 1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0, 0));

    foreach (tbl[i]) begin
      t_rst = tbl[i].rst; t_start = tbl[i].start; t_stop = tbl[i].stop;
      t_clear = tbl[i].clear; t_cfg = DLY_W'(tbl[i].cfg); t_v1 = tbl[i].v1;
      t_v2 = tbl[i].v2; t_vmon = tbl[i].vmon; t_sts = 4'(tbl[i].sts);
      repeat (tbl[i].reps) step();
      chk($sformatf("row%0d_state", i), state_o, tbl[i].e_st);
      chk($sformatf("row%0d_arst", i), aligner_rst_o, tbl[i].e_arst);
      chk($sformatf("row%0d_v1o", i), vld_1st_o, tbl[i].e_v1o);
      chk($sformatf("row%0d_v2o", i), vld_2d_o, tbl[i].e_v2o);
      chk($sformatf("row%0d_busy", i), busy_o, tbl[i].e_busy);
      chk($sformatf("row%0d_retry", i), retry_cnt_o, tbl[i].e_retry);
      chk($sformatf("row%0d_aligned", i), aligned_cnt_o, tbl[i].e_al);
      chk($sformatf("row%0d_delay", i), delay_o, tbl[i].e_dly);
    end

    // Nominal run: 100 aligned pulses.
    to_arm(10);
    t_v1 = 1; step(); t_v1 = 0;
    repeat (9) step();
    t_v2 = 1; step(); t_v2 = 0;
    chk("nominal_run", state_o, 4);
    t_vmon = 1; repeat (100) step(); t_vmon = 0;
    chk("nominal_aligned", aligned_cnt_o, 100);
    chk("nominal_retry", retry_cnt_o, 0);

    // Timeout three times, then ERROR.
    to_arm(10);
    for (int r = 1; r <= 3; r++) begin
      t_v1 = 1; step(); t_v1 = 0;
      chk("to_fill", state_o, 3);
      repeat (10 + MARG - 1) step();
      chk("to_fill_before_limit", state_o, 3);
      step();
      chk("to_recover", state_o, 5);
      chk("to_retry", retry_cnt_o, r);
      chk("to_arst", aligner_rst_o, 1);
      repeat (RSTC - 1) step();
      chk("to_recover_hold", state_o, 5);
      step();
      chk("to_exit", state_o, (r < 3) ? 2 : 7);
    end
    chk("err_flag", err_o, 1);
    chk("err_arst", aligner_rst_o, 1);
    t_start = 1; step(); t_start = 0;
    chk("err_sticky", state_o, 7);
    t_clear = 1; step(); t_clear = 0;
    chk("clear_idle", state_o, 0);
    chk("clear_retry", retry_cnt_o, 0);

    // Second valid on the exact timeout cycle wins.
    to_arm(10);
    t_v1 = 1; step(); t_v1 = 0;
    repeat (10 + MARG - 1) step();
    t_v2 = 1; step(); t_v2 = 0;
    chk("boundary_run", state_o, 4);

    // Stop and status fault in the same cycle: stop wins.
    t_stop = 1; t_sts = 4'b0001; step(); t_stop = 0; t_sts = '0;
    chk("stop_over_fault", state_o, 6);

    // Reset during FILL.
    to_arm(5);
    t_v1 = 1; step(); t_v1 = 0; step();
    chk("rst_fill", state_o, 3);
    t_rst = 1; t_v1 = 1; step(); t_rst = 0; t_v1 = 0;
    chk("rst_state", state_o, 0);
    chk("rst_delay", delay_o, 0);
    chk("rst_arst", aligner_rst_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_retry", retry_cnt_o, 0);

    // Randomized run against the model.
    clr_in();
    t_rst = 1; step(); t_rst = 0;
    for (int c = 0; c < 6000; c++) begin
      int p2;
      p2 = ((c / 600) % 2 == 0) ? 3 : 120;
      t_rst   = ($urandom_range(999, 0) == 0);
      t_start = ($urandom_range(3, 0) == 0);
      t_stop  = ($urandom_range(59, 0) == 0);
      t_clear = ($urandom_range(9, 0) == 0);
      t_cfg   = DLY_W'($urandom_range(30, 0));
      t_v1    = ($urandom_range(3, 0) == 0);
      t_v2    = ($urandom_range(p2 - 1, 0) == 0);
      t_vmon  = $urandom_range(1, 0) == 1;
      t_sts   = ($urandom_range(39, 0) == 0) ? 4'($urandom_range(15, 1)) : 4'd0;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
